// File: rtl/lsu_mem_master.sv
// lsu_mem_master
// Single-outstanding load/store master sitting between a core's LSU request
// channel and a simple strobe-based memory port.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_wen              1 = store, 0 = load
//   req_addr             byte address
//   req_wdata            store data, LSB-justified
//   req_size             0=byte 1=half 2=word 3=dword
//   req_signed           sign-extend loads narrower than a dword
//   resp_valid/ready     response handshake
//   resp_rdata           extended load data (0 for stores and errors)
//   resp_err             misaligned access flag
//   mem_rd_en/addr/data  memory read port; data returns one cycle after the
//                        edge that samples mem_rd_en and is zero otherwise
//   mem_we_en/addr/data/mask  memory write port, data LSB-justified
//
// Every output is forced to zero while rst is high, so a transaction caught
// by reset never emits a strobe or a response in that cycle.

module lsu_mem_master (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_rd_en,
   output logic [63:0] mem_rd_addr,
   input  logic [63:0] mem_rd_data,
   output logic        mem_we_en,
   output logic [63:0] mem_we_addr,
   output logic [63:0] mem_we_data,
   output logic [7:0]  mem_we_mask
);

   typedef enum logic [2:0] {
      IDLE,
      RD_ISSUE,
      RD_WAIT,
      WR_ISSUE,
      RESP
   } state_t;

   state_t      state_reg, state_next;

   // Request fields held for the life of the transaction. The load/store
   // direction is carried by the path through the state machine itself.
   logic [63:0] addr_reg;
   logic [63:0] wdata_reg;
   logic [1:0]  size_reg;
   logic        signed_reg;

   logic [63:0] rdata_reg;
   logic        err_reg;

   logic        accept;
   logic        misaligned;

   assign accept = req_valid && req_ready;

   // Natural alignment check on the incoming request.
   always_comb begin
      misaligned = 1'b0;
      case (req_size)
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = req_addr[0];
         2'd2:    misaligned = |req_addr[1:0];
         default: misaligned = |req_addr[2:0];
      endcase
   end

   // The memory returns the addressed byte in bits [7:0]; keep the low
   // (1<<size) bytes and extend. Dwords are never sign-extended.
   function automatic logic [63:0] extend_load(input logic [63:0] d,
                                               input logic [1:0]  sz,
                                               input logic        sgn);
      logic [63:0] r;
      case (sz)
         2'd0:    r = sgn ? {{56{d[7]}},  d[7:0]}  : {56'd0, d[7:0]};
         2'd1:    r = sgn ? {{48{d[15]}}, d[15:0]} : {48'd0, d[15:0]};
         2'd2:    r = sgn ? {{32{d[31]}}, d[31:0]} : {32'd0, d[31:0]};
         default: r = d;
      endcase
      return r;
   endfunction

   function automatic logic [7:0] size_mask(input logic [1:0] sz);
      logic [7:0] m;
      case (sz)
         2'd0:    m = 8'h01;
         2'd1:    m = 8'h03;
         2'd2:    m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         addr_reg   <= 64'd0;
         wdata_reg  <= 64'd0;
         size_reg   <= 2'd0;
         signed_reg <= 1'b0;
         rdata_reg  <= 64'd0;
         err_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            addr_reg   <= req_addr;
            wdata_reg  <= req_wdata;
            size_reg   <= req_size;
            signed_reg <= req_signed;
            rdata_reg  <= 64'd0;
            err_reg    <= misaligned;
         end
         // Read data is only valid in this one cycle; the memory zeroes it
         // afterwards, so it is extended and parked here.
         if (state_reg == RD_WAIT) begin
            rdata_reg <= extend_load(mem_rd_data, size_reg, signed_reg);
         end
      end
   end

   always_comb begin
      state_next  = state_reg;
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      resp_rdata  = 64'd0;
      resp_err    = 1'b0;
      mem_rd_en   = 1'b0;
      mem_rd_addr = 64'd0;
      mem_we_en   = 1'b0;
      mem_we_addr = 64'd0;
      mem_we_data = 64'd0;
      mem_we_mask = 8'd0;
      if (!rst) begin
         case (state_reg)
            IDLE: begin
               req_ready = 1'b1;
               if (req_valid) begin
                  if (misaligned)   state_next = RESP;
                  else if (req_wen) state_next = WR_ISSUE;
                  else              state_next = RD_ISSUE;
               end
            end
            RD_ISSUE: begin
               mem_rd_en   = 1'b1;
               mem_rd_addr = addr_reg;
               state_next  = RD_WAIT;
            end
            RD_WAIT: begin
               state_next = RESP;
            end
            WR_ISSUE: begin
               mem_we_en   = 1'b1;
               mem_we_addr = addr_reg;
               mem_we_data = wdata_reg;
               mem_we_mask = size_mask(size_reg);
               state_next  = RESP;
            end
            RESP: begin
               resp_valid = 1'b1;
               resp_rdata = rdata_reg;
               resp_err   = err_reg;
               // req_ready stays low here, so the exit cycle cannot accept.
               if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master
// Directed bench for lsu_mem_master. A byte-array memory answers the DUT's
// strobes; a transaction-level model predicts every output cycle by cycle
// from the request (latency, strobe cycle, extended data) and a single
// negedge process compares. Literal checks pin the model on known vectors.

module tb_lsu_mem_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_signed;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic        mem_rd_en;
   logic [63:0] mem_rd_addr;
   logic [63:0] mem_rd_data;
   logic        mem_we_en;
   logic [63:0] mem_we_addr;
   logic [63:0] mem_we_data;
   logic [7:0]  mem_we_mask;

   always #5 clk = ~clk;

   lsu_mem_master dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_wen     (req_wen),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_size    (req_size),
      .req_signed  (req_signed),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_rdata  (resp_rdata),
      .resp_err    (resp_err),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data),
      .mem_we_en   (mem_we_en),
      .mem_we_addr (mem_we_addr),
      .mem_we_data (mem_we_data),
      .mem_we_mask (mem_we_mask)
   );

   // ---------------- memory model (256-byte window, index = addr[7:0]) ----
   logic [255:0][7:0] mem;
   int                rd_pulses = 0;
   int                we_pulses = 0;
   logic [63:0]       last_rd_addr = 64'd0;
   logic [63:0]       last_we_addr = 64'd0;
   logic [63:0]       last_we_data = 64'd0;
   logic [7:0]        last_we_mask = 8'd0;

   function automatic logic [63:0] mem_rd64(input logic [255:0][7:0] m,
                                            input logic [63:0] a);
      logic [63:0] r;
      logic [7:0]  idx;
      r = 64'd0;
      for (int i = 0; i < 8; i++) begin
         idx = a[7:0] + 8'(i);
         r[8*i +: 8] = m[idx];
      end
      return r;
   endfunction

   function automatic logic [255:0][7:0] mem_wr(input logic [255:0][7:0] m,
                                                input logic [63:0] a,
                                                input logic [63:0] d,
                                                input logic [7:0]  mk);
      logic [255:0][7:0] r;
      logic [7:0]        idx;
      r = m;
      for (int i = 0; i < 8; i++) begin
         idx = a[7:0] + 8'(i);
         if (mk[i]) r[idx] = d[8*i +: 8];
      end
      return r;
   endfunction

   always @(posedge clk) begin
      mem_rd_data <= mem_rd_en ? mem_rd64(mem, mem_rd_addr) : 64'd0;
      if (mem_rd_en) begin
         rd_pulses    <= rd_pulses + 1;
         last_rd_addr <= mem_rd_addr;
      end
      if (mem_we_en) begin
         mem          <= mem_wr(mem, mem_we_addr, mem_we_data, mem_we_mask);
         we_pulses    <= we_pulses + 1;
         last_we_addr <= mem_we_addr;
         last_we_data <= mem_we_data;
         last_we_mask <= mem_we_mask;
      end
   end

   // ---------------- expected outputs + compare process ------------------
   int          total = 0;
   int          bad   = 0;
   bit          chk_en = 1'b0;
   logic        exp_req_ready, exp_resp_valid, exp_resp_err;
   logic        exp_rd_en, exp_we_en;
   logic [63:0] exp_resp_rdata, exp_rd_addr, exp_we_addr, exp_we_data;
   logic [7:0]  exp_we_mask;

   task automatic cmp64(input string nm, input logic [63:0] got,
                        input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s t=%0t got=%h want=%h", nm, $time, got, want);
      end
   endtask

   task automatic exp_quiet(input logic rdy);
      exp_req_ready  = rdy;
      exp_resp_valid = 1'b0;
      exp_resp_rdata = 64'd0;
      exp_resp_err   = 1'b0;
      exp_rd_en      = 1'b0;
      exp_rd_addr    = 64'd0;
      exp_we_en      = 1'b0;
      exp_we_addr    = 64'd0;
      exp_we_data    = 64'd0;
      exp_we_mask    = 8'd0;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp64("req_ready",   64'(req_ready),   64'(exp_req_ready));
         cmp64("resp_valid",  64'(resp_valid),  64'(exp_resp_valid));
         cmp64("resp_rdata",  resp_rdata,       exp_resp_rdata);
         cmp64("resp_err",    64'(resp_err),    64'(exp_resp_err));
         cmp64("mem_rd_en",   64'(mem_rd_en),   64'(exp_rd_en));
         cmp64("mem_rd_addr", mem_rd_addr,      exp_rd_addr);
         cmp64("mem_we_en",   64'(mem_we_en),   64'(exp_we_en));
         cmp64("mem_we_addr", mem_we_addr,      exp_we_addr);
         cmp64("mem_we_data", mem_we_data,      exp_we_data);
         cmp64("mem_we_mask", 64'(mem_we_mask), 64'(exp_we_mask));
      end
   end

   // ---------------- transaction driver + model --------------------------
   // Called one time unit after a posedge with the DUT idle. Returns the
   // DUT's observed first-response cycle (counted from the accept edge).
   task automatic run_txn(input bit wen, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [1:0] size,
                          input bit sgn, input int hold,
                          output logic [63:0] got_rdata,
                          output logic got_err, output int got_lat);
      int          n, lat, k;
      bit          mis, done;
      logic [63:0] exp_rd, cur;
      n   = 1 << size;
      mis = (addr % 64'(n)) != 64'd0;
      lat = mis ? 1 : (wen ? 2 : 3);
      exp_rd = 64'd0;
      if (!wen && !mis) begin
         cur = mem_rd64(mem, addr);
         for (int i = 0; i < n; i++) exp_rd[8*i +: 8] = cur[8*i +: 8];
         if (sgn && size != 2'd3 && exp_rd[8*n-1])
            for (int i = 8*n; i < 64; i++) exp_rd[i] = 1'b1;
      end

      req_valid  = 1'b1;
      req_wen    = wen;
      req_addr   = addr;
      req_wdata  = wdata;
      req_size   = size;
      req_signed = sgn;
      resp_ready = (hold == 0);
      exp_quiet(1'b1);
      @(posedge clk); #1;
      // Request fields must be ignored once accepted.
      req_valid  = 1'b0;
      req_wen    = ~wen;
      req_addr   = {$urandom, $urandom};
      req_wdata  = {$urandom, $urandom};
      req_size   = 2'($urandom);
      req_signed = ~sgn;

      got_lat = -1; got_rdata = 64'd0; got_err = 1'b0;
      k = 1; done = 1'b0;
      while (!done && k < 60) begin
         exp_quiet(1'b0);
         if (!mis && k == 1) begin
            if (wen) begin
               exp_we_en   = 1'b1;
               exp_we_addr = addr;
               exp_we_data = wdata;
               exp_we_mask = 8'((1 << n) - 1);
            end else begin
               exp_rd_en   = 1'b1;
               exp_rd_addr = addr;
            end
         end
         if (k >= lat) begin
            exp_resp_valid = 1'b1;
            exp_resp_rdata = exp_rd;
            exp_resp_err   = mis;
            resp_ready     = (k - lat) >= hold;
            done           = resp_ready;
         end
         if (got_lat < 0 && resp_valid === 1'b1) begin
            got_lat   = k;
            got_rdata = resp_rdata;
            got_err   = resp_err;
         end
         @(posedge clk); #1;
         k++;
      end
      if (!done) begin
         total++; bad++;
         $display("FAIL txn_timeout addr=%h", addr);
      end
      resp_ready = 1'b0;
      exp_quiet(1'b1);
      $display("txn %s addr=%h size=%0d signed=%0d hold=%0d lat=%0d rdata=%h err=%0d",
               wen ? "ST" : "LD", addr, size, sgn, hold, got_lat, got_rdata, got_err);
   endtask

   logic [63:0] r_data;
   logic        r_err;
   int          r_lat;
   int          rd0, we0;

   initial begin
      mem = '0;
      mem[8'h03] = 8'h80;
      mem[8'h08] = 8'h88; mem[8'h09] = 8'h77; mem[8'h0A] = 8'h66; mem[8'h0B] = 8'h55;
      mem[8'h0C] = 8'h44; mem[8'h0D] = 8'h33; mem[8'h0E] = 8'h22; mem[8'h0F] = 8'h11;
      rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = 64'd0;
      req_wdata = 64'd0; req_size = 2'd0; req_signed = 1'b0; resp_ready = 1'b0;
      exp_quiet(1'b0);
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_quiet(1'b1);
      @(posedge clk); #1;

      // Signed byte load
      rd0 = rd_pulses;
      run_txn(1'b0, 64'h8000_0003, 64'd0, 2'd0, 1'b1, 0, r_data, r_err, r_lat);
      cmp64("sb_rdata", r_data, 64'hFFFF_FFFF_FFFF_FF80);
      cmp64("sb_err",   64'(r_err), 64'd0);
      cmp64("sb_lat",   64'(r_lat), 64'd3);
      cmp64("sb_pulses", 64'(rd_pulses - rd0), 64'd1);
      cmp64("sb_rdaddr", last_rd_addr, 64'h8000_0003);

      // Unsigned word load
      run_txn(1'b0, 64'h8000_0008, 64'd0, 2'd2, 1'b0, 0, r_data, r_err, r_lat);
      cmp64("lw_rdata", r_data, 64'h0000_0000_5566_7788);

      // Signed byte with top bit set, signed half/word with top bit clear
      run_txn(1'b0, 64'h8000_0008, 64'd0, 2'd0, 1'b1, 0, r_data, r_err, r_lat);
      cmp64("lb8_rdata", r_data, 64'hFFFF_FFFF_FFFF_FF88);
      run_txn(1'b0, 64'h8000_000C, 64'd0, 2'd2, 1'b1, 0, r_data, r_err, r_lat);
      cmp64("lw_c_rdata", r_data, 64'h0000_0000_1122_3344);
      run_txn(1'b0, 64'h8000_000E, 64'd0, 2'd1, 1'b1, 0, r_data, r_err, r_lat);
      cmp64("lh_e_rdata", r_data, 64'h0000_0000_0000_1122);

      // Half store, then read it back
      we0 = we_pulses;
      run_txn(1'b1, 64'h8000_0010, 64'hDEAD_BEEF_CAFE_F00D, 2'd1, 1'b0, 0, r_data, r_err, r_lat);
      cmp64("sh_lat",   64'(r_lat), 64'd2);
      cmp64("sh_rdata", r_data, 64'd0);
      cmp64("sh_pulses", 64'(we_pulses - we0), 64'd1);
      cmp64("sh_addr", last_we_addr, 64'h8000_0010);
      cmp64("sh_mask", 64'(last_we_mask), 64'h03);
      cmp64("sh_data", last_we_data, 64'hDEAD_BEEF_CAFE_F00D);
      run_txn(1'b0, 64'h8000_0010, 64'd0, 2'd3, 1'b0, 0, r_data, r_err, r_lat);
      cmp64("sh_readback", r_data, 64'h0000_0000_0000_F00D);

      // Misaligned dword load and misaligned half store: no strobes
      rd0 = rd_pulses; we0 = we_pulses;
      run_txn(1'b0, 64'h8000_0004, 64'd0, 2'd3, 1'b0, 0, r_data, r_err, r_lat);
      cmp64("mis_err",   64'(r_err), 64'd1);
      cmp64("mis_lat",   64'(r_lat), 64'd1);
      cmp64("mis_rdata", r_data, 64'd0);
      run_txn(1'b1, 64'h8000_0021, 64'h1234, 2'd1, 1'b0, 0, r_data, r_err, r_lat);
      cmp64("mis_st_err", 64'(r_err), 64'd1);
      cmp64("mis_strobes", 64'((rd_pulses - rd0) + (we_pulses - we0)), 64'd0);

      // Backpressure on a dword load (signed flag ignored)
      run_txn(1'b0, 64'h8000_0008, 64'd0, 2'd3, 1'b1, 5, r_data, r_err, r_lat);
      cmp64("bp_rdata", r_data, 64'h1122_3344_5566_7788);
      cmp64("bp_lat",   64'(r_lat), 64'd3);

      // Reset while the store sits in its issue cycle
      we0 = we_pulses;
      req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h8000_0020;
      req_wdata = 64'hA5A5_A5A5_A5A5_A5A5; req_size = 2'd3; req_signed = 1'b0;
      resp_ready = 1'b1;
      exp_quiet(1'b1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b1;
      exp_quiet(1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_quiet(1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      cmp64("rst_we_pulses", 64'(we_pulses - we0), 64'd0);
      cmp64("rst_mem_untouched", mem_rd64(mem, 64'h8000_0020), 64'd0);
      $display("txn RST-ST addr=%h we_pulses=%0d", 64'h8000_0020, we_pulses - we0);

      // Back-to-back after the reset still works
      run_txn(1'b0, 64'h8000_0003, 64'd0, 2'd0, 1'b0, 0, r_data, r_err, r_lat);
      cmp64("post_rst_rdata", r_data, 64'h0000_0000_0000_0080);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
